// File: rtl/serial_pkg.sv
// Shared types and constants for the serial bit feeder and its bench.
package serial_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts words over valid/ready and emits one bit per clock,
// with a one-word holding register so consecutive frames run with no idle gap.
module serial_bit_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             accept;

    assign accept = data_valid && !hold_full;

    // On the last bit, a held word takes priority; otherwise a word accepted that edge bypasses hold.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sreg      <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sreg  <= data_in;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt != LAST) begin
                        if (MSB_FIRST)
                            sreg <= {sreg[WIDTH-2:0], 1'b0};
                        else
                            sreg <= {1'b0, sreg[WIDTH-1:1]};
                        cnt <= cnt + 1'b1;
                        if (accept) begin
                            hold      <= data_in;
                            hold_full <= 1'b1;
                        end
                    end else if (hold_full) begin
                        sreg      <= hold;
                        hold_full <= 1'b0;
                        cnt       <= '0;
                    end else if (accept) begin
                        sreg <= data_in;
                        cnt  <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign data_ready  = !hold_full;
    assign bit_valid   = (state == S_SHIFT);
    assign x_out       = bit_valid ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT;
    assign frame_start = bit_valid && (cnt == '0);
    assign frame_done  = bit_valid && (cnt == LAST);
    assign busy        = bit_valid || hold_full;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a frame-level queue model, plus directed literal checks.
module tb_serial_bit_feeder;
    import serial_pkg::*;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;

    logic ready_m, x_m, bv_m, fs_m, fd_m, busy_m;
    logic ready_l, x_l, bv_l, fs_l, fd_l, busy_l;

    int total = 0;
    int bad = 0;
    bit checkEn = 1'b0;

    // Model: current frame word and bit index, plus queue of accepted-but-unstarted words
    logic [W-1:0] curWord = '0;
    int           curIdx = 0;
    bit           active = 1'b0;
    logic [W-1:0] waitQ[$];

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_LEVEL)) dut_msb (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_m), .x_out(x_m), .bit_valid(bv_m),
        .frame_start(fs_m), .frame_done(fd_m), .busy(busy_m)
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_LEVEL)) dut_lsb (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_l), .x_out(x_l), .bit_valid(bv_l),
        .frame_start(fs_l), .frame_done(fd_l), .busy(busy_l)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance: one word may wait at most; a word starts right after the previous one ends
    always @(posedge clock) begin
        bit acc;
        if (!reset) begin
            active = 1'b0;
            curIdx = 0;
            waitQ.delete();
        end else begin
            acc = data_valid && (waitQ.size() == 0);
            if (active) begin
                if (curIdx == W - 1) begin
                    if (waitQ.size() > 0) begin
                        curWord = waitQ.pop_front();
                        curIdx = 0;
                    end else if (acc) begin
                        curWord = data_in;
                        curIdx = 0;
                    end else begin
                        active = 1'b0;
                    end
                end else begin
                    curIdx++;
                    if (acc) waitQ.push_back(data_in);
                end
            end else if (acc) begin
                active = 1'b1;
                curWord = data_in;
                curIdx = 0;
            end
        end
    end

    always @(negedge clock) begin
        logic expBitM, expBitL, expStart, expDone, expBusy, expReady;
        if (checkEn) begin
            expBitM  = active ? curWord[W-1-curIdx] : IDLE_LEVEL;
            expBitL  = active ? curWord[curIdx] : IDLE_LEVEL;
            expStart = active && (curIdx == 0);
            expDone  = active && (curIdx == W - 1);
            expBusy  = active || (waitQ.size() > 0);
            expReady = (waitQ.size() == 0);
            checkOutput("msb x_out", {31'd0, x_m}, {31'd0, expBitM});
            checkOutput("msb bit_valid", {31'd0, bv_m}, {31'd0, active});
            checkOutput("msb frame_start", {31'd0, fs_m}, {31'd0, expStart});
            checkOutput("msb frame_done", {31'd0, fd_m}, {31'd0, expDone});
            checkOutput("msb busy", {31'd0, busy_m}, {31'd0, expBusy});
            checkOutput("msb data_ready", {31'd0, ready_m}, {31'd0, expReady});
            checkOutput("lsb x_out", {31'd0, x_l}, {31'd0, expBitL});
            checkOutput("lsb bit_valid", {31'd0, bv_l}, {31'd0, active});
            checkOutput("lsb frame_start", {31'd0, fs_l}, {31'd0, expStart});
            checkOutput("lsb frame_done", {31'd0, fd_l}, {31'd0, expDone});
            checkOutput("lsb busy", {31'd0, busy_l}, {31'd0, expBusy});
            checkOutput("lsb data_ready", {31'd0, ready_l}, {31'd0, expReady});
        end
    end

    // Offer one word for a single edge and capture the following W bits from both instances
    task automatic applyStimulus(input logic [W-1:0] word, output logic [W-1:0] gotM,
                                 output logic [W-1:0] gotL, output int starts, output int dones);
        data_in = word;
        data_valid = 1'b1;
        starts = 0;
        dones = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clock);
            data_valid = 1'b0;
            gotM[W-1-i] = x_m;
            gotL[i] = x_l;
            if (fs_m && i == 0) starts++;
            if (fd_m && i == W - 1) dones++;
        end
        @(negedge clock);
    endtask

    initial begin
        logic [W-1:0] gm, gl;
        logic [15:0] stream;
        int st, dn, nValid;
        bit readyLow, readyHigh;

        // Reset held two edges while a word is offered
        reset = 1'b0;
        data_valid = 1'b1;
        data_in = 8'hFF;
        @(posedge clock);
        @(negedge clock);
        checkEn = 1'b1;
        @(negedge clock);
        checkOutput("reset data_ready", {31'd0, ready_m}, 32'd1);
        checkOutput("reset bit_valid", {31'd0, bv_m}, 32'd0);
        checkOutput("reset x_out", {31'd0, x_m}, 32'd0);
        checkOutput("reset busy", {31'd0, busy_m}, 32'd0);
        data_valid = 1'b0;
        reset = 1'b1;
        nValid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bv_m) nValid++;
        end
        checkOutput("no frame after reset", nValid, 0);

        // Single word, both bit orders
        applyStimulus(8'hA5, gm, gl, st, dn);
        checkOutput("A5 msb bits", {24'd0, gm}, 32'hA5);
        checkOutput("A5 lsb bits", {24'd0, gl}, 32'hA5);
        checkOutput("A5 frame_start", st, 1);
        checkOutput("A5 frame_done", dn, 1);
        checkOutput("A5 idle after", {31'd0, bv_m}, 32'd0);
        applyStimulus(8'h01, gm, gl, st, dn);
        checkOutput("01 lsb first bit", {31'd0, gl[0]}, 32'd1);
        checkOutput("01 lsb bits", {24'd0, gl}, 32'h01);
        checkOutput("01 frame_done", dn, 1);

        // Back-to-back through the holding register
        data_in = 8'hF0;
        data_valid = 1'b1;
        stream = '0;
        nValid = 0;
        readyLow = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            stream = {stream[14:0], x_m};
            if (bv_m) nValid++;
            if (c == 1) data_in = 8'h0F;
            if (c == 2) data_valid = 1'b0;
            if (c >= 2 && c <= 8 && ready_m) readyLow = 1'b0;
            if (c == 9) checkOutput("b2b second frame_start", {31'd0, fs_m}, 32'd1);
        end
        checkOutput("b2b stream", {16'd0, stream}, 32'hF00F);
        checkOutput("b2b contiguous valid", nValid, 16);
        checkOutput("b2b ready low k+2..k+8", {31'd0, readyLow}, 32'd1);
        repeat (2) @(negedge clock);

        // Last-bit bypass
        data_in = 8'h81;
        data_valid = 1'b1;
        stream = '0;
        readyHigh = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            stream = {stream[14:0], x_m};
            if (!ready_m) readyHigh = 1'b0;
            data_valid = 1'b0;
            if (c == 8) begin
                checkOutput("bypass frame_done", {31'd0, fd_m}, 32'd1);
                data_in = 8'h3C;
                data_valid = 1'b1;
            end
        end
        checkOutput("bypass stream", {16'd0, stream}, 32'h813C);
        checkOutput("bypass hold unused", {31'd0, readyHigh}, 32'd1);
        repeat (2) @(negedge clock);

        // Reset mid-frame discards current and held words
        data_in = 8'hFF;
        data_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            if (c == 1) data_in = 8'h55;
            if (c == 2) data_valid = 1'b0;
            if (c == 4) reset = 1'b0;
        end
        checkOutput("midreset bit_valid", {31'd0, bv_m}, 32'd0);
        checkOutput("midreset x_out", {31'd0, x_m}, 32'd0);
        checkOutput("midreset data_ready", {31'd0, ready_m}, 32'd1);
        checkOutput("midreset busy", {31'd0, busy_m}, 32'd0);
        reset = 1'b1;
        nValid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bv_m) nValid++;
        end
        checkOutput("held word dropped", nValid, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            data_valid = ($urandom_range(0, 99) < 55);
            data_in = W'($urandom);
            reset = ($urandom_range(0, 249) != 0);
            @(negedge clock);
        end
        data_valid = 1'b0;
        reset = 1'b1;
        repeat (20) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
